// File: rtl/ssp_host_ctrl.sv
// ssp_host_ctrl: bus initiator for the synchronous serial port.
//   Moves outgoing bytes from a valid/ready stream into the port TX FIFO
//   with single-cycle write transfers. Drains the port RX FIFO with read
//   transfers into a small local buffer exposed as a valid/ready stream.
//
// Ports:
//   PCLK, CLEAR        clock, synchronous active-high reset
//   tx_word/valid/ready  outgoing byte stream (tx_ready is combinational)
//   rx_word/valid/ready  incoming byte stream (head of local buffer)
//   drain_req          one-cycle pulse: request one extra read
//   PSEL/PWRITE/PWDATA registered bus outputs toward the port
//   PRDATA             read data from the port
//   SSPTXINTR          port TX FIFO full (stalls writes)
//   SSPRXINTR          port RX FIFO full (triggers a FIFO_DEPTH-word drain)
//   busy               FSM away from IDLE or reads still pending
//
// state   | meaning
// IDLE    | arbitrate: pending read first, then outgoing byte
// WR      | write transfer on the bus (PSEL=1, PWRITE=1)
// RD      | read transfer on the bus (PSEL=1, PWRITE=0)
// RD_WAIT | waiting READ_LAT cycles, then capture PRDATA into local buffer
module ssp_host_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int RXBUF_DEPTH = 4,
  parameter int READ_LAT    = 1
) (
  input  logic       PCLK,
  input  logic       CLEAR,
  input  logic [7:0] tx_word,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_word,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       drain_req,
  output logic       PSEL,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       SSPTXINTR,
  input  logic       SSPRXINTR,
  output logic       busy
);

  localparam int AW = $clog2(RXBUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] PEND_LOAD = (FIFO_DEPTH > 15) ? 4'hF : 4'(FIFO_DEPTH);
  localparam logic [1:0] LAT_LOAD  = 2'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;

  state_t        state, state_nxt;
  logic [3:0]    pend, pend_base, pend_nxt;
  logic [1:0]    lat_cnt;
  logic [7:0]    mem [RXBUF_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, free;
  logic          push, pop, rx_load, rd_want, rd_go, accept, rd_done;

  assign rx_valid = (count != '0);
  assign pop      = rx_valid & rx_ready;
  // Space available this cycle, crediting a pop happening right now.
  assign free     = CW'(RXBUF_DEPTH) - count + {{(CW-1){1'b0}}, pop};

  assign rx_load  = (state == IDLE) && SSPRXINTR && (pend == 4'd0);
  // A drain request or a fresh RX-full load counts as pending immediately,
  // so a read wins over a byte offered in the same cycle.
  assign rd_want  = (pend != 4'd0) || drain_req || rx_load;
  assign rd_go    = (state == IDLE) && rd_want && (free != '0);
  assign tx_ready = (state == IDLE) && !rd_go && !SSPTXINTR && !CLEAR;
  assign accept   = tx_valid && tx_ready;
  assign rd_done  = (state == RD_WAIT) && (lat_cnt == 2'd0);
  assign push     = rd_done;

  assign rx_word  = rx_valid ? mem[rd_ptr] : 8'h00;
  assign busy     = (state != IDLE) || (pend != 4'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_go)       state_nxt = RD;
        else if (accept) state_nxt = WR;
      end
      WR:      state_nxt = IDLE;
      RD:      state_nxt = RD_WAIT;
      RD_WAIT: if (lat_cnt == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Increment and decrement in the same cycle cancel out.
  always_comb begin
    pend_base = rx_load ? PEND_LOAD : pend;
    pend_nxt  = pend_base;
    if (drain_req && !rd_done)
      pend_nxt = (pend_base == 4'hF) ? 4'hF : pend_base + 4'd1;
    else if (rd_done && !drain_req)
      pend_nxt = pend_base - 4'd1;
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      state   <= IDLE;
      pend    <= 4'd0;
      lat_cnt <= 2'd0;
      PSEL    <= 1'b0;
      PWRITE  <= 1'b0;
      PWDATA  <= 8'h00;
    end else begin
      state  <= state_nxt;
      pend   <= pend_nxt;
      PSEL   <= (state_nxt == WR) || (state_nxt == RD);
      PWRITE <= (state_nxt == WR);
      if (accept) PWDATA <= tx_word;
      if (state == RD)
        lat_cnt <= LAT_LOAD;
      else if ((state == RD_WAIT) && (lat_cnt != 2'd0))
        lat_cnt <= lat_cnt - 2'd1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge PCLK) begin
    if (push && !CLEAR) mem[wr_ptr] <= PRDATA;
  end

endmodule

// File: tb/tb_ssp_host_ctrl.sv
module tb_ssp_host_ctrl;

  logic       PCLK = 1'b0;
  logic       CLEAR;
  logic [7:0] tx_word;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_word;
  logic       rx_valid;
  logic       rx_ready;
  logic       drain_req;
  logic       PSEL;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA = 8'h00;
  logic       SSPTXINTR;
  logic       SSPRXINTR;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_reads = 0;
  bit prev_psel = 1'b0;

  logic [7:0] wr_exp [$];
  logic [7:0] rd_src [$];
  logic [7:0] rx_exp [$];
  int         wr_cycles [$];
  int         last_rd_cyc = 0;

  ssp_host_ctrl #(.FIFO_DEPTH(4), .RXBUF_DEPTH(4), .READ_LAT(1)) dut (
    .PCLK(PCLK), .CLEAR(CLEAR),
    .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_word(rx_word), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .drain_req(drain_req),
    .PSEL(PSEL), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .SSPTXINTR(SSPTXINTR), .SSPRXINTR(SSPRXINTR), .busy(busy)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Bus / peripheral model and RX consumer scoreboard, sampled mid-cycle.
  always @(negedge PCLK) begin
    logic [7:0] v;
    if (PSEL === 1'b1) begin
      chk("psel_gap", {31'd0, prev_psel}, 32'd0);
      if (PWRITE === 1'b1) begin
        wr_cycles.push_back(cyc);
        chk("wr_expected", {31'd0, wr_exp.size() != 0}, 32'd1);
        if (wr_exp.size() != 0) chk("pwdata", {24'd0, PWDATA}, {24'd0, wr_exp.pop_front()});
      end else begin
        n_reads++;
        last_rd_cyc = cyc;
        v = (rd_src.size() != 0) ? rd_src.pop_front() : 8'hEE;
        PRDATA = v;
        rx_exp.push_back(v);
      end
    end
    prev_psel = (PSEL === 1'b1);
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      chk("rx_expected", {31'd0, rx_exp.size() != 0}, 32'd1);
      if (rx_exp.size() != 0) chk("rx_word", {24'd0, rx_word}, {24'd0, rx_exp.pop_front()});
    end
  end

  // Offer one byte; entered and left at 1 time unit after a rising edge.
  task automatic send(input logic [7:0] w);
    bit done = 1'b0;
    tx_valid = 1'b1;
    tx_word  = w;
    for (int i = 0; i < 30 && !done; i++) begin
      #1;
      if (tx_ready === 1'b1) begin
        wr_exp.push_back(w);
        done = 1'b1;
      end
      @(posedge PCLK);
      #1;
    end
    tx_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int r0, b0;
    bit ok;
    CLEAR = 1'b1; tx_valid = 1'b1; tx_word = 8'hA5; rx_ready = 1'b0;
    drain_req = 1'b0; SSPTXINTR = 1'b0; SSPRXINTR = 1'b0;

    // Reset: every output low while CLEAR is high.
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("reset_outputs", {13'd0, PSEL, PWRITE, PWDATA, tx_ready, rx_valid, rx_word, busy}, 32'd0);
    end
    tick();
    CLEAR = 1'b0;
    #1;
    chk("first_accept", {31'd0, tx_ready}, 32'd1);
    wr_exp.push_back(8'hA5);
    tick();
    tx_valid = 1'b0;
    chk("first_write", {22'd0, PSEL, PWRITE, PWDATA}, {22'd0, 2'b11, 8'hA5});
    tick();
    chk("first_write_one_cycle", {31'd0, PSEL}, 32'd0);

    // Streamed writes, one every two cycles.
    b0 = wr_cycles.size();
    for (int i = 1; i <= 4; i++) send(8'(i));
    tick(); tick();
    chk("stream_count", wr_cycles.size(), b0 + 4);
    if (wr_cycles.size() == b0 + 4)
      for (int i = 1; i < 4; i++)
        chk("stream_spacing", wr_cycles[b0+i] - wr_cycles[b0+i-1], 32'd2);

    // TX FIFO full stalls the offered byte without loss.
    SSPTXINTR = 1'b1; tx_valid = 1'b1; tx_word = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_ready", {31'd0, tx_ready}, 32'd0);
      chk("stall_psel", {31'd0, PSEL}, 32'd0);
      tick();
    end
    SSPTXINTR = 1'b0;
    #1;
    chk("unstall_ready", {31'd0, tx_ready}, 32'd1);
    wr_exp.push_back(8'h5A);
    tick();
    tx_valid = 1'b0;
    chk("unstall_write", {22'd0, PSEL, PWRITE, PWDATA}, {22'd0, 2'b11, 8'h5A});
    tick();

    // RX-full drain of four words with consumer always ready.
    for (int i = 0; i < 4; i++) rd_src.push_back(8'h10 + 8'(i));
    rx_ready = 1'b1;
    r0 = n_reads;
    SSPRXINTR = 1'b1;
    tick();
    SSPRXINTR = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = (n_reads - r0 == 4) && (busy === 1'b0) && (rx_exp.size() == 0) && (rx_valid === 1'b0);
    end
    chk("drain4_done", {31'd0, ok}, 32'd1);
    chk("drain4_reads", n_reads - r0, 32'd4);
    chk("drain4_idle", {31'd0, busy}, 32'd0);

    // Full local buffer stalls extra reads until the consumer pops.
    for (int i = 0; i < 6; i++) rd_src.push_back(8'h20 + 8'(i));
    rx_ready = 1'b0;
    r0 = n_reads;
    SSPRXINTR = 1'b1;
    tick();
    SSPRXINTR = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("fill_reads", n_reads - r0, 32'd4);
    for (int i = 0; i < 2; i++) begin
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      tick();
    end
    for (int i = 0; i < 8; i++) tick();
    chk("stall_reads", n_reads - r0, 32'd4);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 2; k++) begin
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("pop_release", n_reads - r0, 32'(4 + k));
    end
    rx_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("total_reads", n_reads - r0, 32'd6);
    chk("drain6_idle", {30'd0, busy, rx_valid}, 32'd0);
    chk("drain6_scoreboard", rx_exp.size(), 32'd0);

    // Read wins over a byte offered in the same cycle.
    rd_src.push_back(8'h30);
    tx_valid = 1'b1; tx_word = 8'h77; drain_req = 1'b1;
    #1;
    chk("rd_priority_ready", {31'd0, tx_ready}, 32'd0);
    tick();
    drain_req = 1'b0;
    chk("rd_first", {30'd0, PSEL, PWRITE}, {30'd0, 2'b10});
    send(8'h77);
    tick(); tick();
    chk("wr_after_rd", {31'd0, (wr_cycles.size() != 0) && (wr_cycles[$] > last_rd_cyc)}, 32'd1);
    chk("wr_queue_empty", wr_exp.size(), 32'd0);

    // Reset while waiting for read data: the word is discarded.
    rx_ready = 1'b0;
    rd_src.push_back(8'h3C);
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    chk("rd_before_clear", {30'd0, PSEL, PWRITE}, {30'd0, 2'b10});
    tick();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    rx_exp.delete();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("clear_abort_outputs", {29'd0, PSEL, rx_valid, busy}, 32'd0);
      chk("clear_abort_word", {31'd0, rx_word === 8'h3C}, 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
